// File: rtl/i2c_inject.sv
// i2c_inject: single-master I2C write engine with open-drain line enables.
// Sends START, {dev_addr,W}, ACK, one or more payload bytes (each with ACK),
// then STOP. The master parks in WAIT with SCL held low whenever the next
// payload byte is not ready.
//
// Build option: define I2C_CLK_STRETCH_EN to let a slave stretch the clock.
// The divider then freezes during SCL-high phases while scl_in reads low.
// When the macro is undefined, scl_in is ignored and timing depends only on
// CLK_DIV.
module i2c_inject #(
   parameter int unsigned CLK_DIV = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] dev_addr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic [3:0] state
);

   localparam int unsigned DIV_W = 8;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_START = 4'd1;
   localparam logic [3:0] S_ADDR  = 4'd2;
   localparam logic [3:0] S_AACK  = 4'd3;
   localparam logic [3:0] S_WAIT  = 4'd4;
   localparam logic [3:0] S_DATA  = 4'd5;
   localparam logic [3:0] S_DACK  = 4'd6;
   localparam logic [3:0] S_STOP  = 4'd7;

   logic [3:0]       state_q, state_d;
   logic [1:0]       phase_q, phase_d;
   logic [2:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic             last_q, last_d;
   logic             busy_d, nack_d, done_d, tx_ready_d;
   logic             scl_oe_d, sda_oe_d;
   logic             sel_bit;
   logic             run;
   logic             stretch;
   logic             tick;

   // Line enables for a given state/phase; b is the data bit of the slot.
   function automatic logic [1:0] bus_lines(input logic [3:0] st,
                                            input logic [1:0] ph,
                                            input logic       b);
      logic [1:0] l;
      l = 2'b00;
      case (st)
         S_START:        l = (ph < 2'd2) ? 2'b00 : 2'b01;
         S_ADDR, S_DATA: l = {(ph < 2'd2), ~b};
         S_AACK, S_DACK: l = {(ph < 2'd2), 1'b0};
         S_WAIT:         l = 2'b10;
         S_STOP: begin
            if (ph < 2'd2)       l = 2'b11;
            else if (ph == 2'd2) l = 2'b01;
            else                 l = 2'b00;
         end
         default:        l = 2'b00;
      endcase
      return l;
   endfunction

`ifdef I2C_CLK_STRETCH_EN
   // Freeze the divider while a slave holds SCL low during an SCL-high phase.
   always_comb begin
      stretch = 1'b0;
      if (!scl_in) begin
         case (state_q)
            S_ADDR, S_AACK, S_DATA, S_DACK: stretch = phase_q[1];
            S_STOP:                         stretch = (phase_q == 2'd2);
            default:                        stretch = 1'b0;
         endcase
      end
   end
`else
   logic unused_scl_in;
   assign unused_scl_in = scl_in;
   assign stretch       = 1'b0;
`endif

   // Phase tick: the divider runs everywhere except IDLE and WAIT.
   assign run  = (state_q != S_IDLE) && (state_q != S_WAIT);
   assign tick = run && !stretch && (div_q == DIV_LAST);

   // Next-state, counters and registered-output values.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_d      = bit_q;
      div_d      = div_q;
      addr_d     = addr_q;
      data_d     = data_q;
      last_d     = last_q;
      busy_d     = busy;
      nack_d     = nack;
      done_d     = 1'b0;
      tx_ready_d = 1'b0;

      if (!run)          div_d = '0;
      else if (stretch)  div_d = div_q;
      else if (tick)     div_d = '0;
      else               div_d = div_q + DIV_W'(1);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = {dev_addr, 1'b0};
               nack_d  = 1'b0;
               busy_d  = 1'b1;
               phase_d = 2'd0;
               state_d = S_START;
            end
         end

         S_START: begin
            if (tick) begin
               if (phase_q == 2'd3) begin
                  phase_d = 2'd0;
                  bit_d   = 3'd7;
                  state_d = S_ADDR;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end

         S_ADDR, S_DATA: begin
            if (tick) begin
               if (phase_q == 2'd3) begin
                  phase_d = 2'd0;
                  if (bit_q == 3'd0)
                     state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
                  else
                     bit_d = bit_q - 3'd1;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end

         S_AACK, S_DACK: begin
            if (tick) begin
               if (phase_q == 2'd3) begin
                  phase_d = 2'd0;
                  if (sda_in) begin
                     nack_d  = 1'b1;
                     state_d = S_STOP;
                  end else if ((state_q == S_DACK) && last_q) begin
                     state_d = S_STOP;
                  end else if (tx_valid) begin
                     data_d     = tx_data;
                     last_d     = tx_last;
                     tx_ready_d = 1'b1;
                     bit_d      = 3'd7;
                     state_d    = S_DATA;
                  end else begin
                     state_d = S_WAIT;
                  end
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end

         S_WAIT: begin
            if (tx_valid) begin
               data_d     = tx_data;
               last_d     = tx_last;
               tx_ready_d = 1'b1;
               bit_d      = 3'd7;
               phase_d    = 2'd0;
               state_d    = S_DATA;
            end
         end

         S_STOP: begin
            if (tick) begin
               if (phase_q == 2'd3) begin
                  phase_d = 2'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  phase_d = phase_q + 2'd1;
               end
            end
         end

         default: begin
            phase_d = 2'd0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      sel_bit = (state_d == S_ADDR) ? addr_d[bit_d] : data_d[bit_d];
      {scl_oe_d, sda_oe_d} = bus_lines(state_d, phase_d, sel_bit);
   end

   // State, counters and registered outputs; reset releases both lines at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         phase_q  <= 2'd0;
         bit_q    <= 3'd0;
         div_q    <= '0;
         addr_q   <= 8'd0;
         data_q   <= 8'd0;
         last_q   <= 1'b0;
         busy     <= 1'b0;
         nack     <= 1'b0;
         done     <= 1'b0;
         tx_ready <= 1'b0;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         bit_q    <= bit_d;
         div_q    <= div_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         last_q   <= last_d;
         busy     <= busy_d;
         nack     <= nack_d;
         done     <= done_d;
         tx_ready <= tx_ready_d;
         scl_oe   <= scl_oe_d;
         sda_oe   <= sda_oe_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_i2c_inject.sv
// tb_i2c_inject: directed checks of the i2c_inject write engine at CLK_DIV=2.
module tb_i2c_inject;

   localparam int unsigned CLK_DIV = 2;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [6:0] dev_addr;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       scl_in;
   logic       sda_in;
   logic       scl_oe;
   logic       sda_oe;
   logic       busy;
   logic       done;
   logic       nack;
   logic [3:0] state;

   i2c_inject #(.CLK_DIV(CLK_DIV)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .start    (start),
      .dev_addr (dev_addr),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_last  (tx_last),
      .tx_ready (tx_ready),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .scl_oe   (scl_oe),
      .sda_oe   (sda_oe),
      .busy     (busy),
      .done     (done),
      .nack     (nack),
      .state    (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Per-transaction observations.
   int         r_len;
   int         r_acnt;
   int         r_dcnt;
   int         r_ready;
   int         r_wcnt;
   logic [7:0] r_abits;
   logic [7:0] r_dbits;
   logic [3:0] r_after_aack;
   logic       r_wait_bad;
   logic       r_done;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive one single-byte write and record what appears on the bus.
   task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input logic ack_bad,
                         input int hold_valid, input bit do_stretch, input int poke_len,
                         input bit rst_mid);
      logic       prev_scl;
      logic [3:0] prev_st;
      bit         stretched;
      int         left;
      @(negedge clk);
      dev_addr = a;
      tx_data  = d;
      tx_last  = 1'b1;
      tx_valid = (hold_valid == 0);
      sda_in   = ack_bad;
      scl_in   = 1'b1;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("enter_start", 32'(state), 32'd1);
      check("busy_set", 32'(busy), 32'd1);
      check("nack_cleared", 32'(nack), 32'd0);
      r_len = 0; r_acnt = 0; r_dcnt = 0; r_ready = 0; r_wcnt = 0;
      r_abits = 8'h00; r_dbits = 8'h00; r_after_aack = 4'hF;
      r_wait_bad = 1'b0; r_done = 1'b0;
      prev_scl = scl_oe; prev_st = state; stretched = 1'b0; left = 0;
      for (int i = 0; i < 1000 && !r_done; i++) begin
         start = 1'b0;
         @(negedge clk);
         r_len++;
         if (prev_scl && !scl_oe) begin
            if (state == 4'd2) begin
               r_abits = {r_abits[6:0], ~sda_oe};
               r_acnt++;
            end else if (state == 4'd5) begin
               r_dbits = {r_dbits[6:0], ~sda_oe};
               r_dcnt++;
            end
         end
         prev_scl = scl_oe;
         if (prev_st == 4'd3 && state != 4'd3) r_after_aack = state;
         prev_st = state;
         if (tx_ready) begin
            r_ready++;
            check("ready_enters_data", 32'(state), 32'd5);
            tx_valid = 1'b0;
         end
         if (state == 4'd4) begin
            r_wcnt++;
            if (!scl_oe || sda_oe) r_wait_bad = 1'b1;
            if (r_wcnt == hold_valid) tx_valid = 1'b1;
         end
         if (left > 0) begin
            left--;
            if (left == 0) scl_in = 1'b1;
         end else if (do_stretch && !stretched && r_acnt == 8) begin
            scl_in    = 1'b0;
            left      = 20;
            stretched = 1'b1;
         end
         if (done) r_done = 1'b1;
         if (poke_len > 0 && r_len == poke_len) begin
            start    = 1'b1;
            dev_addr = 7'h7F;
         end
         if (rst_mid && r_dcnt == 5) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_mid_scl", 32'(scl_oe), 32'd0);
            check("rst_mid_sda", 32'(sda_oe), 32'd0);
            check("rst_mid_state", 32'(state), 32'd0);
            check("rst_mid_busy", 32'(busy), 32'd0);
            tx_valid = 1'b0;
            return;
         end
      end
      start = 1'b0;
      check("txn_done", 32'(r_done), 32'd1);
   endtask

   task automatic check_idle_after(input string tag);
      @(negedge clk);
      check({tag, "_done_width"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(state), 32'd0);
      check({tag, "_busy_clr"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; dev_addr = 7'h00; tx_data = 8'h00;
      tx_valid = 1'b0; tx_last = 1'b0; scl_in = 1'b1; sda_in = 1'b0;
      #2;
      check("rst_scl", 32'(scl_oe), 32'd0);
      check("rst_sda", 32'(sda_oe), 32'd0);
      check("rst_state", 32'(state), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(tx_ready), 32'd0);
      check("rst_nack", 32'(nack), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_idle", 32'(state), 32'd0);

      // Basic write; start poked during START must not relatch the address.
      do_txn(7'h2A, 8'h5B, 1'b0, 0, 1'b0, 3, 1'b0);
      check("a_len", 32'(r_len), 32'd160);
      check("a_addr_bits", 32'(r_abits), 32'h54);
      check("a_addr_cnt", 32'(r_acnt), 32'd8);
      check("a_data_bits", 32'(r_dbits), 32'h5B);
      check("a_data_cnt", 32'(r_dcnt), 32'd8);
      check("a_ready_cnt", 32'(r_ready), 32'd1);
      check("a_after_aack", 32'(r_after_aack), 32'd5);
      check("a_nack", 32'(nack), 32'd0);
      check_idle_after("a");

      // Slave NACKs the address; start poked during STOP is ignored.
      do_txn(7'h2A, 8'h5B, 1'b1, 0, 1'b0, 82, 1'b0);
      check("b_len", 32'(r_len), 32'd88);
      check("b_addr_bits", 32'(r_abits), 32'h54);
      check("b_after_aack", 32'(r_after_aack), 32'd7);
      check("b_ready_cnt", 32'(r_ready), 32'd0);
      check("b_data_cnt", 32'(r_dcnt), 32'd0);
      check("b_nack", 32'(nack), 32'd1);
      check_idle_after("b");
      check("b_nack_sticky", 32'(nack), 32'd1);

      // Payload late by 50 clk: the master parks in WAIT with SCL low.
      do_txn(7'h13, 8'hA6, 1'b0, 50, 1'b0, 0, 1'b0);
      check("c_len", 32'(r_len), 32'd210);
      check("c_wait_cnt", 32'(r_wcnt), 32'd50);
      check("c_wait_lines", 32'(r_wait_bad), 32'd0);
      check("c_after_aack", 32'(r_after_aack), 32'd4);
      check("c_ready_cnt", 32'(r_ready), 32'd1);
      check("c_addr_bits", 32'(r_abits), 32'h26);
      check("c_data_bits", 32'(r_dbits), 32'hA6);
      check_idle_after("c");

      // Slave holds SCL low for 20 clk in the high half of address bit 0.
      do_txn(7'h2A, 8'h5B, 1'b0, 0, 1'b1, 0, 1'b0);
`ifdef I2C_CLK_STRETCH_EN
      check("d_len_stretch", 32'(r_len), 32'd180);
`else
      check("d_len_fixed", 32'(r_len), 32'd160);
`endif
      check("d_addr_bits", 32'(r_abits), 32'h54);
      check("d_data_bits", 32'(r_dbits), 32'h5B);
      check_idle_after("d");

      // Reset during data bit 3: lines released at once, no STOP afterwards.
      do_txn(7'h2A, 8'h5B, 1'b0, 0, 1'b0, 0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("e_idle_after_rst", 32'(state), 32'd0);
      check("e_scl_released", 32'(scl_oe), 32'd0);
      check("e_sda_released", 32'(sda_oe), 32'd0);
      do_txn(7'h55, 8'hC3, 1'b0, 0, 1'b0, 0, 1'b0);
      check("e_len", 32'(r_len), 32'd160);
      check("e_addr_bits", 32'(r_abits), 32'hAA);
      check("e_data_bits", 32'(r_dbits), 32'hC3);
      check("e_nack", 32'(nack), 32'd0);
      check_idle_after("e");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
